// File: rtl/z8086_pic.sv
// Eight-input interrupt controller for the z8086 core: request latching, masking, fixed
// priority, in-service tracking and the inta vector cycle, programmed via three byte registers.
module z8086_pic #(
    parameter bit         LEVEL      = 1'b0,
    parameter logic [7:0] IMR_RESET  = 8'hFF,
    parameter logic [7:0] BASE_RESET = 8'h08
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [7:0]  i_irq,
    input  logic        i_cs,
    input  logic [1:0]  i_a,
    input  logic        i_wr,
    input  logic        i_rd,
    input  logic [7:0]  i_wdata,
    output logic [7:0]  o_rdata,
    output logic        o_rdy,
    output logic        o_intr,
    input  logic        i_inta,
    output logic [15:0] o_vec
);

    function automatic logic [2:0] f_low_idx(input logic [7:0] v);
        f_low_idx = 3'd7;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) f_low_idx = 3'(i);
        end
    endfunction

    logic [7:0] r_s1, r_s2, r_s3;
    logic [7:0] r_irr, r_isr, r_imr;
    logic [4:0] r_base;
    logic       r_inta_q, r_ack_go;
    logic       r_req_wr, r_req_rd;
    logic [1:0] r_req_a;
    logic [7:0] r_req_wdata;
    logic       r_intr, r_rdy;
    logic [7:0] r_rdata;
    logic [15:0] r_vec;

    logic [7:0] w_pend, w_ack_bit, w_eoi_bit, w_irr_next, w_isr_next, w_rd_mux;
    logic [2:0] w_win, w_isr_low;
    logic       w_has, w_intr_next;

    always_comb begin
        w_pend      = r_irr & ~r_imr;
        w_has       = |w_pend;
        w_win       = f_low_idx(w_pend);
        w_isr_low   = f_low_idx(r_isr);
        w_ack_bit   = (r_ack_go && w_has) ? (8'b1 << w_win) : 8'h00;
        w_eoi_bit   = 8'h00;
        if (r_req_wr && (r_req_a == 2'd0) && r_req_wdata[5] && (r_isr != 8'h00)) begin
            w_eoi_bit = 8'b1 << w_isr_low;
        end
        // A fresh edge wins over the acknowledge clear of the same bit.
        w_irr_next  = LEVEL ? r_s2 : ((r_irr & ~w_ack_bit) | (r_s2 & ~r_s3));
        w_isr_next  = (r_isr & ~w_eoi_bit) | w_ack_bit;
        w_intr_next = w_has && ((r_isr == 8'h00) || (w_win < w_isr_low));
        unique case (r_req_a)
            2'd0:    w_rd_mux = r_irr;
            2'd1:    w_rd_mux = r_imr;
            2'd2:    w_rd_mux = r_isr;
            default: w_rd_mux = 8'h00;
        endcase
    end

    // r_inta_q resets high so an inta held across reset release is not taken as a new cycle.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_s1        <= 8'h00;
            r_s2        <= 8'h00;
            r_s3        <= 8'h00;
            r_irr       <= 8'h00;
            r_isr       <= 8'h00;
            r_imr       <= IMR_RESET;
            r_base      <= BASE_RESET[7:3];
            r_inta_q    <= 1'b1;
            r_ack_go    <= 1'b0;
            r_req_wr    <= 1'b0;
            r_req_rd    <= 1'b0;
            r_req_a     <= 2'd0;
            r_req_wdata <= 8'h00;
            r_intr      <= 1'b0;
            r_rdy       <= 1'b0;
            r_rdata     <= 8'h00;
            r_vec       <= 16'h0000;
        end else begin
            r_s1        <= i_irq;
            r_s2        <= r_s1;
            r_s3        <= r_s2;
            r_irr       <= w_irr_next;
            r_isr       <= w_isr_next;
            r_inta_q    <= i_inta;
            r_ack_go    <= i_inta & ~r_inta_q;
            r_req_wr    <= i_cs & i_wr;
            r_req_rd    <= i_cs & i_rd;
            r_req_a     <= i_a;
            r_req_wdata <= i_wdata;
            r_intr      <= w_intr_next;
            r_rdy       <= r_ack_go | r_req_wr | r_req_rd;
            r_rdata     <= r_req_rd ? w_rd_mux : 8'h00;
            r_vec       <= r_ack_go ? {8'h00, r_base, (w_has ? w_win : 3'd7)} : 16'h0000;
            if (r_req_wr && (r_req_a == 2'd1)) r_imr <= r_req_wdata;
            if (r_req_wr && (r_req_a == 2'd2)) r_base <= r_req_wdata[7:3];
        end
    end

    assign o_intr  = r_intr;
    assign o_rdy   = r_rdy;
    assign o_rdata = r_rdata;
    assign o_vec   = r_vec;

endmodule

// File: tb/tb_z8086_pic.sv
// Directed self-checking bench for z8086_pic: reset, ack, priority/nesting, masking,
// spurious vector and reset during an acknowledge.
module tb_z8086_pic;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  irq = 8'h00;
    logic        cs = 1'b0;
    logic [1:0]  a = 2'd0;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic [7:0]  wdata = 8'h00;
    logic [7:0]  rdata;
    logic        rdy;
    logic        intr;
    logic        inta = 1'b0;
    logic [15:0] vec;

    int checks = 0;
    int failures = 0;

    z8086_pic dut (
        .i_clk    (clk),
        .i_reset_n(reset_n),
        .i_irq    (irq),
        .i_cs     (cs),
        .i_a      (a),
        .i_wr     (wr),
        .i_rd     (rd),
        .i_wdata  (wdata),
        .o_rdata  (rdata),
        .o_rdy    (rdy),
        .o_intr   (intr),
        .i_inta   (inta),
        .o_vec    (vec)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic reg_write(input string tag, input logic [1:0] addr, input logic [7:0] d);
        cs = 1'b1; wr = 1'b1; a = addr; wdata = d;
        tick();
        cs = 1'b0; wr = 1'b0;
        tick();
        check({tag, "_wr_rdy"}, {15'd0, rdy}, 16'd1);
    endtask

    task automatic reg_read(input string tag, input logic [1:0] addr, input logic [7:0] exp);
        cs = 1'b1; rd = 1'b1; a = addr;
        tick();
        cs = 1'b0; rd = 1'b0;
        tick();
        check({tag, "_rdy"}, {15'd0, rdy}, 16'd1);
        check(tag, {8'h00, rdata}, {8'h00, exp});
        tick();
        check({tag, "_rdy_off"}, {15'd0, rdy}, 16'd0);
        check({tag, "_rdata_off"}, {8'h00, rdata}, 16'h0000);
    endtask

    // Raise inta for one rising edge; rdy/vec are checked one edge after it is sampled.
    task automatic do_ack(input string tag, input logic [15:0] exp_vec);
        inta = 1'b1;
        tick();
        check({tag, "_rdy_early"}, {15'd0, rdy}, 16'd0);
        tick();
        check({tag, "_rdy"}, {15'd0, rdy}, 16'd1);
        check({tag, "_vec"}, vec, exp_vec);
        inta = 1'b0;
        tick();
        check({tag, "_rdy_off"}, {15'd0, rdy}, 16'd0);
        check({tag, "_vec_off"}, vec, 16'h0000);
    endtask

    initial begin
        // Reset
        tick(); tick(); tick();
        check("rst_intr", {15'd0, intr}, 16'd0);
        check("rst_rdy", {15'd0, rdy}, 16'd0);
        check("rst_vec", vec, 16'h0000);
        reset_n = 1'b1;
        tick();
        reg_read("rst_imr", 2'd1, 8'hFF);
        reg_read("rst_irr", 2'd0, 8'h00);
        reg_read("rst_isr", 2'd2, 8'h00);
        reg_read("a3_read", 2'd3, 8'h00);

        // Basic acknowledge
        reg_write("imr_df", 2'd1, 8'hDF);
        reg_write("base_00", 2'd2, 8'h00);
        irq = 8'h20;
        tick();
        irq = 8'h00;
        tick();
        check("basic_intr_n1", {15'd0, intr}, 16'd0);
        tick();
        check("basic_intr_n2", {15'd0, intr}, 16'd0);
        tick();
        check("basic_intr_n3", {15'd0, intr}, 16'd1);
        do_ack("basic_ack", 16'h0005);
        check("basic_intr_low", {15'd0, intr}, 16'd0);
        reg_read("basic_isr", 2'd2, 8'h20);
        reg_write("basic_eoi", 2'd0, 8'h20);
        reg_read("basic_isr_clr", 2'd2, 8'h00);

        // Priority and nesting
        reg_write("imr_00", 2'd1, 8'h00);
        reg_write("base_08", 2'd2, 8'h08);
        irq = 8'h28;
        tick();
        irq = 8'h00;
        tick(); tick(); tick();
        check("prio_intr", {15'd0, intr}, 16'd1);
        do_ack("prio_ack1", 16'h000B);
        check("prio_intr_blocked", {15'd0, intr}, 16'd0);
        reg_read("prio_isr1", 2'd2, 8'h08);
        check("prio_intr_blocked2", {15'd0, intr}, 16'd0);
        reg_read("prio_irr", 2'd0, 8'h20);
        reg_write("prio_eoi1", 2'd0, 8'h20);
        tick();
        check("prio_intr_reassert", {15'd0, intr}, 16'd1);
        do_ack("prio_ack2", 16'h000D);
        check("prio_intr_low", {15'd0, intr}, 16'd0);
        reg_read("prio_isr2", 2'd2, 8'h20);
        reg_write("prio_eoi2", 2'd0, 8'h20);
        reg_read("prio_isr_clr", 2'd2, 8'h00);

        // Masking
        reg_write("imr_ff", 2'd1, 8'hFF);
        irq = 8'h04;
        tick();
        irq = 8'h00;
        tick(); tick(); tick(); tick();
        check("mask_intr_off", {15'd0, intr}, 16'd0);
        reg_read("mask_irr", 2'd0, 8'h04);
        reg_write("imr_fb", 2'd1, 8'hFB);
        check("mask_intr_w1", {15'd0, intr}, 16'd0);
        tick();
        check("mask_intr_w2", {15'd0, intr}, 16'd1);
        do_ack("mask_ack", 16'h000A);
        reg_read("mask_isr", 2'd2, 8'h04);
        reg_write("mask_eoi", 2'd0, 8'h20);
        reg_read("mask_irr_clr", 2'd0, 8'h00);

        // Spurious acknowledge
        do_ack("spur_ack", 16'h000F);
        reg_read("spur_isr", 2'd2, 8'h00);
        check("spur_intr", {15'd0, intr}, 16'd0);

        // Reset in the middle of an acknowledge
        irq = 8'h04;
        tick();
        irq = 8'h00;
        tick(); tick(); tick();
        check("rack_intr", {15'd0, intr}, 16'd1);
        inta = 1'b1;
        tick();
        reset_n = 1'b0;
        #1;
        check("rack_rdy_async", {15'd0, rdy}, 16'd0);
        check("rack_vec_async", vec, 16'h0000);
        check("rack_intr_async", {15'd0, intr}, 16'd0);
        tick(); tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rack_no_rdy", {15'd0, rdy}, 16'd0);
        end
        inta = 1'b0;
        tick();
        check("rack_intr_after", {15'd0, intr}, 16'd0);
        reg_read("rack_irr", 2'd0, 8'h00);
        reg_read("rack_isr", 2'd2, 8'h00);
        reg_read("rack_imr", 2'd1, 8'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
